spi_frame_sequencer: RTL
========================

# spi_frame_sequencer

Frame-level controller between the SPI slave front end and the design's configuration shift registers. Consumes the slave's per-bit strobe stream, decodes the first byte of each chip-select frame as a target index, and routes the remaining payload bits into exactly one target shift register. Frame length is checked at chip-select deassertion; the block then either pulses a one-cycle commit to the selected target or flags an error.

## Interface
- NUM_TARGETS, 4, number of downstream shift registers (1..16)
- MAX_BYTES, 8, largest entry of TARGET_BYTES; sizes the byte counter
- clk  input  1  system clock; all logic on rising edge
- resetN  input  1  asynchronous, active-low reset
- serialIn  input  1  data bit from SPI slave, valid when serialEn=1
- serialEn  input  1  one-cycle strobe per received bit, MSB first
- csN  input  1  synchronized chip select, active low, same clk domain
- tgtSerialOut  output  1  shared payload bit to all targets
- tgtSerialEn  output  NUM_TARGETS  one-hot shift enable, selected target only
- tgtCommit  output  NUM_TARGETS  one-cycle pulse: target contents valid
- frameError  output  1  one-cycle pulse: frame rejected
- busy  output  1  high whenever state != IDLE

## Operation
- States: IDLE, HEADER, PAYLOAD, DISCARD, END.
- IDLE: csN=1. serialEn ignored. csN sampled 0 -> HEADER, bit/byte counters cleared.
- HEADER: shift 8 bits into header register. After 8th bit: header < NUM_TARGETS -> PAYLOAD, target=header; else -> DISCARD.
- PAYLOAD: each serialEn forwards serialIn on tgtSerialOut with tgtSerialEn[target]=1. Bit counter 3 bits, wraps 7->0 and increments byte counter. Once TARGET_BYTES[target] bytes have been forwarded, further bits are not forwarded but are still counted; byte counter saturates at MAX_BYTES+1.
- DISCARD: bits counted, never forwarded.
- csN sampled 1 in any non-IDLE state -> END.
- END, one cycle, decides:
  - Commit: state was PAYLOAD, bit counter = 0, and byte count = TARGET_BYTES[target]. Pulse tgtCommit[target].
  - Otherwise: pulse frameError. Causes are short, long or partial-byte frames, bad header, or csN rising during HEADER.
  - Then -> IDLE.
- Same-cycle serialEn and csN=1: the bit is counted, and forwarded if eligible, before the END decision.
- Reset mid-frame: all outputs 0, state IDLE, no commit or error pulse. Target contents are undefined but never committed.

## Timing
- Reset values: tgtSerialOut=0, tgtSerialEn=0, tgtCommit=0, frameError=0, busy=0.
- tgtSerialOut/tgtSerialEn are registered: one clk after the serialEn cycle, width exactly one cycle.
- Commit and error are mutually exclusive, one pulse per frame. They are asserted two clk after the first csN=1 sample: END entered, then registered pulse.
- busy rises the cycle after csN=0 is first sampled and falls with the END-to-IDLE transition.
- Back-to-back frames: csN=0 sampled in END is honoured; the next frame goes to HEADER directly from END with no lost bits.

## Configuration
- SPI_FRAME_CHECKSUM_EN defined: each frame carries one trailing byte after the payload, equal to the XOR of all payload bytes.
  - The checksum byte is accumulated internally and never forwarded.
  - Commit additionally requires byte count = TARGET_BYTES[target]+1 and checksum match; a mismatch pulses frameError.
- Macro undefined: no trailing byte and no checksum logic.

## Structure
- Package spi_frame_pkg holds:
  - state enum type
  - TARGET_BYTES constant array, default {1,2,3,4} for indices 0..3
  - HEADER_BITS=8
- One sub-module, spi_bit_counter: 3-bit wrap counter plus saturating byte counter, with clear and increment inputs and a byteDone flag.

## Test plan
- Header 0x01, payload 0xA5 0x3C (plus checksum 0x99 if enabled), csN high -> 16 tgtSerialEn[1] pulses carrying bits A53C MSB-first, tgtCommit=4'b0010, frameError=0.
- Header 0x02, payload 2 bytes, target expects 3 -> 16 bits forwarded to target 2, frameError pulse, tgtCommit=0.
- Header 0x07 with NUM_TARGETS=4, 3 payload bytes -> no tgtSerialEn activity, frameError pulse.
- Header 0x00, 1 byte plus 3 extra bits -> first 8 bits forwarded, extra bits not forwarded, frameError pulse.
- resetN low mid-PAYLOAD of target 3 -> all outputs 0 immediately, busy=0, no commit. Next frame with header 0x03 and 4 bytes commits tgtCommit=4'b1000.
- Checksum build: header 0x00, payload 0x5A, checksum 0x5B -> frameError. Same frame with checksum 0x5A -> tgtCommit=4'b0001.

Source files
------------

// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg: shared types and constants for the SPI frame sequencer.
//   state_t       frame FSM states
//   HEADER_BITS   width of the target-index header
//   TARGET_BYTES  payload length in bytes expected by each target
package spi_frame_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_DISCARD,
    S_END
  } state_t;

  localparam int HEADER_BITS = 8;
  localparam int MAX_TARGETS = 16;

  // Entries past index 3 are placeholders for builds with more targets.
  localparam logic [7:0] TARGET_BYTES [0:MAX_TARGETS-1] = '{
    8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd1, 8'd1, 8'd1,
    8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1
  };

  function automatic logic [7:0] tgt_bytes(input logic [3:0] idx);
    return TARGET_BYTES[idx];
  endfunction

endpackage

// File: rtl/spi_frame_sequencer_bit_counter.sv
// spi_bit_counter: 3-bit bit counter wrapping 7->0, with a byte counter
// that advances on each wrap and saturates at MAX_BYTES+1.
//   i_clear    synchronous clear, wins over i_incr
//   i_incr     count one bit
//   o_bitCnt   bits of the current byte
//   o_byteCnt  completed bytes (saturating)
//   o_byteDone this increment completes a byte
module spi_bit_counter #(
  parameter int MAX_BYTES = 8,
  parameter int BW        = $clog2(MAX_BYTES + 2)
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          i_clear,
  input  logic          i_incr,
  output logic [2:0]    o_bitCnt,
  output logic [BW-1:0] o_byteCnt,
  output logic          o_byteDone
);

  localparam logic [BW-1:0] SAT = BW'(MAX_BYTES + 1);

  logic [2:0]    r_bit;
  logic [BW-1:0] r_byte;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_bit  <= '0;
      r_byte <= '0;
    end else if (i_clear) begin
      r_bit  <= '0;
      r_byte <= '0;
    end else if (i_incr) begin
      r_bit <= r_bit + 3'd1;
      if (r_bit == 3'd7 && r_byte != SAT)
        r_byte <= r_byte + 1'b1;
    end
  end

  assign o_bitCnt   = r_bit;
  assign o_byteCnt  = r_byte;
  assign o_byteDone = i_incr && (r_bit == 3'd7);

endmodule

// File: rtl/spi_frame_sequencer.sv
// spi_frame_sequencer: decodes the first byte of each chip-select frame
// as a target index, streams the payload to that target's shift register
// and, at chip-select release, pulses either a commit for the target or
// frameError.
//   clk, resetN          clock, async active-low reset
//   serialIn, serialEn   bit stream from the SPI slave (MSB first)
//   csN                  synchronized chip select, active low
//   tgtSerialOut/En      registered payload bit + one-hot shift enable
//   tgtCommit            one-cycle commit pulse to the selected target
//   frameError           one-cycle frame rejection pulse
//   busy                 frame in progress
// Optional feature: SPI_FRAME_CHECKSUM_EN adds a trailing XOR checksum byte.
module spi_frame_sequencer
  import spi_frame_pkg::*;
#(
  parameter int NUM_TARGETS = 4,
  parameter int MAX_BYTES   = 8
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   serialIn,
  input  logic                   serialEn,
  input  logic                   csN,
  output logic                   tgtSerialOut,
  output logic [NUM_TARGETS-1:0] tgtSerialEn,
  output logic [NUM_TARGETS-1:0] tgtCommit,
  output logic                   frameError,
  output logic                   busy
);

  localparam int BW = $clog2(MAX_BYTES + 2);

  state_t                 r_state, w_stateNxt;
  logic [7:0]             r_hdr;
  logic [3:0]             r_tgt;
  logic                   r_wasPay;
  logic                   r_tgtSerialOut;
  logic [NUM_TARGETS-1:0] r_tgtSerialEn, r_tgtCommit, w_sel;
  logic                   r_frameError;

  logic [2:0]    w_bitCnt;
  logic [BW-1:0] w_byteCnt;
  logic          w_byteDone, w_clear, w_incr;
  logic          w_commit, w_err, w_loadTgt, w_fwd, w_frameOk;
  logic [7:0]    w_bytes, w_tgtBytes, w_hdrNxt;
  logic          w_hdrOk, w_lenOk, w_sumOk;

  spi_bit_counter #(.MAX_BYTES(MAX_BYTES), .BW(BW)) u_cnt (
    .clk       (clk),
    .resetN    (resetN),
    .i_clear   (w_clear),
    .i_incr    (w_incr),
    .o_bitCnt  (w_bitCnt),
    .o_byteCnt (w_byteCnt),
    .o_byteDone(w_byteDone)
  );

  assign w_bytes    = 8'(w_byteCnt);
  assign w_tgtBytes = tgt_bytes(r_tgt);
  assign w_hdrNxt   = {r_hdr[HEADER_BITS-2:0], serialIn};
  assign w_hdrOk    = w_hdrNxt < 8'(NUM_TARGETS);
  assign w_incr     = serialEn && (r_state inside {S_HEADER, S_PAYLOAD, S_DISCARD});
  // Bits past the target's length are still counted, just not forwarded.
  assign w_fwd      = serialEn && (r_state == S_PAYLOAD) && (w_bytes < w_tgtBytes);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TARGETS; gi++) begin : g_sel
      assign w_sel[gi] = (r_tgt == 4'(gi));
    end
  endgenerate

`ifdef SPI_FRAME_CHECKSUM_EN
  // Payload bytes and the trailing checksum byte are XORed bitwise into one
  // accumulator; a matching checksum leaves it at zero.
  logic [7:0] r_chk;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      r_chk <= '0;
    else if (w_clear)
      r_chk <= '0;
    else if (serialEn && r_state == S_PAYLOAD && w_bytes <= w_tgtBytes)
      r_chk[3'd7 - w_bitCnt] <= r_chk[3'd7 - w_bitCnt] ^ serialIn;
  end

  assign w_lenOk = (w_bytes == w_tgtBytes + 8'd1);
  assign w_sumOk = (r_chk == 8'd0);
`else
  assign w_lenOk = (w_bytes == w_tgtBytes);
  assign w_sumOk = 1'b1;
`endif

  // Counters in END already include any bit that arrived with csN rising.
  assign w_frameOk = r_wasPay && (w_bitCnt == 3'd0) && w_lenOk && w_sumOk;

  always_comb begin
    w_stateNxt = r_state;
    w_clear    = 1'b0;
    w_commit   = 1'b0;
    w_err      = 1'b0;
    w_loadTgt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!csN) begin
          w_stateNxt = S_HEADER;
          w_clear    = 1'b1;
        end
      end
      S_HEADER: begin
        if (csN) begin
          w_stateNxt = S_END;
        end else if (w_byteDone) begin
          // Restart counting so payload byte 0 starts at zero.
          w_clear = 1'b1;
          if (w_hdrOk) begin
            w_stateNxt = S_PAYLOAD;
            w_loadTgt  = 1'b1;
          end else begin
            w_stateNxt = S_DISCARD;
          end
        end
      end
      S_PAYLOAD, S_DISCARD: begin
        if (csN) w_stateNxt = S_END;
      end
      S_END: begin
        if (w_frameOk) w_commit = 1'b1;
        else           w_err    = 1'b1;
        if (!csN) begin
          w_stateNxt = S_HEADER;
          w_clear    = 1'b1;
        end else begin
          w_stateNxt = S_IDLE;
        end
      end
      default: w_stateNxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state        <= S_IDLE;
      r_hdr          <= '0;
      r_tgt          <= '0;
      r_wasPay       <= 1'b0;
      r_tgtSerialOut <= 1'b0;
      r_tgtSerialEn  <= '0;
      r_tgtCommit    <= '0;
      r_frameError   <= 1'b0;
    end else begin
      r_state  <= w_stateNxt;
      r_wasPay <= (r_state == S_PAYLOAD);
      if (r_state == S_HEADER && serialEn)
        r_hdr <= w_hdrNxt;
      if (w_loadTgt)
        r_tgt <= w_hdrNxt[3:0];
      r_tgtSerialOut <= w_fwd & serialIn;
      r_tgtSerialEn  <= w_fwd ? w_sel : '0;
      r_tgtCommit    <= w_commit ? w_sel : '0;
      r_frameError   <= w_err;
    end
  end

  assign tgtSerialOut = r_tgtSerialOut;
  assign tgtSerialEn  = r_tgtSerialEn;
  assign tgtCommit    = r_tgtCommit;
  assign frameError   = r_frameError;
  assign busy         = (r_state != S_IDLE);

endmodule
